// File: rtl/fp_pkg.sv
`default_nettype none
// fp_pkg: shared IEEE-754 single-precision constants and divider FSM encodings.
// Reusable by the FPMult multiplier.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIVIDE = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// fp_unpack: splits an IEEE single into sign/exponent/significand and classifies it.
// Denormals are reported as zero with a zero significand.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]      op,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [MAN_W:0]   sig,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  logic w_exp_max;
  logic w_frac_nz;

  assign sign      = op[31];
  assign exponent  = op[30:23];
  assign w_exp_max = &op[30:23];
  assign w_frac_nz = |op[22:0];
  assign is_zero   = (op[30:23] == '0);
  assign is_inf    = w_exp_max & ~w_frac_nz;
  assign is_nan    = w_exp_max & w_frac_nz;
  assign sig       = is_zero ? '0 : {1'b1, op[22:0]};

endmodule
`default_nettype wire

// File: rtl/fp_div_iter.sv
`default_nettype none
// fp_div_iter: iterative IEEE-754 single divider Q = A / B, radix-2 restoring, RNE, FTZ.
// Optional macro FPDIV_EARLY_DONE_EN: special operands skip DIVIDE/ROUND.
module fp_div_iter #(
  parameter int QBITS    = 26,
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Q,
  output logic        div_zero,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow
);
  import fp_pkg::*;

  div_state_t r_state, w_next;

  logic [31:0] r_a, r_b;
  logic        w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;

  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_mb;
  logic [25:0]        r_rem;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  logic               r_special;

  logic [31:0] r_res_q;
  logic        r_res_dz, r_res_inv, r_res_ovf, r_res_unf;

  fp_unpack u_unpack_a (
    .op(r_a), .sign(w_sa), .exponent(w_ea), .sig(w_ma),
    .is_zero(w_za), .is_inf(w_ia), .is_nan(w_na)
  );

  fp_unpack u_unpack_b (
    .op(r_b), .sign(w_sb), .exponent(w_eb), .sig(w_mb),
    .is_zero(w_zb), .is_inf(w_ib), .is_nan(w_nb)
  );

  logic              w_sign;
  logic signed [9:0] w_exp;
  assign w_sign = w_sa ^ w_sb;
  assign w_exp  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + $signed(10'(EXP_BIAS));

  // Special-operand classification; priority order keeps inf/0 as plain inf.
  logic        w_special, w_spec_inv, w_spec_dz;
  logic [31:0] w_spec_q;
  always_comb begin
    w_special  = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_dz  = 1'b0;
    w_spec_q   = QNAN;
    if (w_na || w_nb || (w_za && w_zb) || (w_ia && w_ib)) begin
      w_spec_inv = 1'b1;
    end else if (w_ia) begin
      w_spec_q = {w_sign, POS_INF[30:0]};
    end else if (w_zb) begin
      w_spec_q  = {w_sign, POS_INF[30:0]};
      w_spec_dz = 1'b1;
    end else if (w_ib || w_za) begin
      w_spec_q = {w_sign, 31'b0};
    end else begin
      w_special = 1'b0;
    end
  end

  logic        w_ge;
  logic [25:0] w_rem_sub;
  assign w_ge      = (r_rem >= {2'b00, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;

  logic [25:0]       w_qn;
  logic signed [9:0] w_en, w_ef;
  logic              w_guard, w_sticky, w_rup;
  logic [24:0]       w_sig_r;
  logic [22:0]       w_man;
  assign w_qn     = r_q[25] ? r_q : (r_q << 1);
  assign w_en     = r_q[25] ? r_exp : (r_exp - 10'sd1);
  assign w_guard  = w_qn[1];
  assign w_sticky = w_qn[0] | (r_rem != '0);
  assign w_rup    = w_guard & (w_sticky | w_qn[2]);
  assign w_sig_r  = {1'b0, w_qn[25:2]} + {24'b0, w_rup};
  assign w_ef     = w_sig_r[24] ? (w_en + 10'sd1) : w_en;
  assign w_man    = w_sig_r[24] ? w_sig_r[23:1] : w_sig_r[22:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start && !done) w_next = S_UNPACK;
`ifdef FPDIV_EARLY_DONE_EN
      S_UNPACK: w_next = w_special ? S_DONE : S_DIVIDE;
`else
      S_UNPACK: w_next = S_DIVIDE;
`endif
      S_DIVIDE: if (r_cnt == 5'(QBITS - 1)) w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      Q         <= '0;
      div_zero  <= 1'b0;
      invalid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_mb      <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_special <= 1'b0;
      r_res_q   <= '0;
      r_res_dz  <= 1'b0;
      r_res_inv <= 1'b0;
      r_res_ovf <= 1'b0;
      r_res_unf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !done) begin
            r_a  <= A;
            r_b  <= B;
            busy <= 1'b1;
          end
        end
        S_UNPACK: begin
          r_sign    <= w_sign;
          r_exp     <= w_exp;
          r_mb      <= w_mb;
          r_rem     <= {2'b00, w_ma};
          r_q       <= '0;
          r_cnt     <= '0;
          r_special <= w_special;
          if (w_special) begin
            r_res_q   <= w_spec_q;
            r_res_dz  <= w_spec_dz;
            r_res_inv <= w_spec_inv;
            r_res_ovf <= 1'b0;
            r_res_unf <= 1'b0;
          end
        end
        S_DIVIDE: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= w_rem_sub << 1;
          r_cnt <= r_cnt + 5'd1;
        end
        S_ROUND: begin
          if (!r_special) begin
            r_res_dz  <= 1'b0;
            r_res_inv <= 1'b0;
            r_res_ovf <= 1'b0;
            r_res_unf <= 1'b0;
            if (w_ef >= 10'sd255) begin
              r_res_q   <= {r_sign, POS_INF[30:0]};
              r_res_ovf <= 1'b1;
            end else if (w_ef <= 10'sd0) begin
              r_res_q   <= {r_sign, 31'b0};
              r_res_unf <= 1'b1;
            end else begin
              r_res_q   <= {r_sign, w_ef[7:0], w_man};
            end
          end
        end
        S_DONE: begin
          Q         <= r_res_q;
          div_zero  <= r_res_dz;
          invalid   <= r_res_inv;
          overflow  <= r_res_ovf;
          underflow <= r_res_unf;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_div_iter.sv
`default_nettype none
// tb_fp_div_iter: directed self-checking bench for fp_div_iter.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B, Q;
  logic        busy, done, div_zero, invalid, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q),
    .div_zero(div_zero), .invalid(invalid),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;   // {div_zero, invalid, overflow, underflow}
    logic        sp;  // special operand case
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV] = '{
    '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0},
    '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b0},
    '{32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000, 1'b0},
    '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 4'b0000, 1'b0},
    '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1000, 1'b1},
    '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0100, 1'b1},
    '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0100, 1'b1},
    '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0100, 1'b1},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1'b1},
    '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 1'b1},
    '{32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 1'b1},
    '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1'b1},
    '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 1'b0},
    '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 1'b0},
    '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1000, 1'b1}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_latency(input logic sp);
`ifdef FPDIV_EARLY_DONE_EN
    return sp ? 2 : 29;
`else
    return (sp === 1'bx) ? 0 : 29;
`endif
  endfunction

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    A = v.a; B = v.b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_set", 32'(busy), 32'd1);
    wait_done(lat);
    check("latency", 32'(lat), 32'(exp_latency(v.sp)));
    check("q", Q, v.q);
    check("flags", {28'b0, div_zero, invalid, overflow, underflow}, 32'(v.f));
    check("busy_clr", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("q_hold", Q, v.q);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n_done;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", Q, 32'd0);
    check("rst_flags", {28'b0, div_zero, invalid, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // start held high: second operand set must wait until after done
    @(negedge clk);
    A = vecs[0].a; B = vecs[0].b; start = 1'b1;
    @(posedge clk);
    #1;
    A = vecs[1].a; B = vecs[1].b;
    wait_done(lat);
    check("hold_latency1", 32'(lat), 32'd29);
    check("hold_q1", Q, vecs[0].q);
    @(posedge clk);
    #1;
    check("hold_ignored_in_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("hold_accept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat);
    check("hold_latency2", 32'(lat), 32'd29);
    check("hold_q2", Q, vecs[1].q);
    @(posedge clk);
    #1;

    // reset during DIVIDE cycle 10
    @(negedge clk);
    A = vecs[0].a; B = vecs[0].b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", Q, 32'd0);
    check("abort_flags", {28'b0, div_zero, invalid, overflow, underflow}, 32'd0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_vec(vecs[1]);
    run_vec(vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Iterative IEEE-754 single-precision divider, Q = A / B. It is the inverse-operation companion to the FPMult multiplier in the floating-point datapath.
- Radix-2 restoring mantissa division, one quotient bit per clock, so no DSP48E1 is consumed.
- start/busy/done handshake so a controller can sequence operations.
- Denormal inputs and outputs are flushed to zero. Rounding is round-to-nearest-even only.

Parameters:
- QBITS, 26, quotient bits generated: 24 significand + guard + round. The sticky bit comes from a nonzero final remainder. Only 26 is supported.
- EXP_BIAS, 127, IEEE single exponent bias.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  32  dividend, IEEE single.
- B  input  32  divisor, IEEE single.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; Q and flags are valid in that cycle and then held.
- Q  output  32  quotient.
- div_zero  output  1  finite nonzero / zero.
- invalid  output  1  0/0, inf/inf, or any NaN operand.
- overflow  output  1  result rounded to infinity from finite operands.
- underflow  output  1  nonzero result flushed to zero.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: busy=0, done=0, Q=32'h0, all flags 0, state=IDLE.
- rst asserted mid-operation aborts the operation. The next cycle is IDLE with all outputs at reset values, and no done pulse is produced.
- FSM states: IDLE -> UNPACK -> DIVIDE (QBITS cycles, 5-bit counter) -> ROUND -> DONE -> IDLE.
- IDLE: a start edge latches A and B and moves to UNPACK. start in any other state is ignored; operands are not re-latched.
- UNPACK:
  - Classify each operand as zero (exp==0, denormals included), inf, NaN, or normal.
  - Form 24-bit significands with the hidden bit.
  - Compute the 10-bit signed exponent eA - eB + EXP_BIAS.
  - sign = A[31]^B[31].
  - If a special case applies, latch the special result and flags; the divide loop still runs but its result is discarded.
- Special results:
  - NaN or invalid -> 32'h7FC00000 with invalid=1.
  - x/0 with x finite nonzero -> signed inf, div_zero=1.
  - inf/finite -> signed inf.
  - finite/inf or 0/finite -> signed zero.
- DIVIDE: remainder R (26 bits) starts at mA. Each cycle:
  - If R >= mB: the quotient bit is 1 and R is replaced by R - mB.
  - Otherwise the quotient bit is 0.
  - In both cases R is then shifted left by 1.
  - 26 cycles produce q[25:0]. The sticky bit = (R != 0) after the last step.
- ROUND:
  - If q[25]==0 (mA < mB), shift q left by 1 and decrement the exponent.
  - RNE on significand q[25:2], with guard = q[1] and sticky = q[0] | remainder-sticky.
  - A mantissa carry-out increments the exponent.
  - Biased exponent >= 255 -> signed inf, overflow=1.
  - Biased exponent <= 0 -> signed zero, underflow=1.
- DONE: Q and flags are registered, done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- Latency: the start sampled at edge 0 gives done=1 in the cycle after edge 29 (UNPACK 1 + DIVIDE 26 + ROUND 1 + DONE 1). The latency is identical for all operands unless the optional feature is enabled.
- Back-to-back: a new start is accepted on the cycle after done (IDLE). start in the DONE cycle is ignored.
- Q and flags hold their values until the next done or rst.

Optional Feature:
- Macro: FPDIV_EARLY_DONE_EN.
- Defined: special-operand cases go UNPACK -> DONE directly. done then arrives 2 cycles after start, and the DIVIDE and ROUND states are skipped.
- Undefined: fixed 29-cycle latency for all inputs.

Decomposition:
- Shared header/package fp_pkg:
  - Constants EXP_BIAS, EXP_W=8, MAN_W=23.
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - FSM state encodings.
- fp_pkg is reusable by FPMult.
- Natural sub-module fp_unpack (combinational): 32-bit operand in; outputs sign, exponent, 24-bit significand, is_zero, is_inf, is_nan. It is instantiated twice and also usable in FPMult.

Test Plan:
1. A=0x40C00000 (6.0), B=0x40000000 (2.0), start pulse -> done exactly 29 cycles later, Q=0x40400000, all flags 0.
2. A=0x3F800000, B=0x40400000 (1/3) -> Q=0x3EAAAAAB (RNE rounds up); also A=0xBF800000, B=0x3F800000 -> Q=0xBF800000.
3. A=0x3F800000, B=0x00000000 -> Q=0x7F800000, div_zero=1; A=B=0x00000000 -> Q=0x7FC00000, invalid=1; A=0x7F800000, B=0x7F800000 -> Q=0x7FC00000, invalid=1.
4. A=0x7F7FFFFF, B=0x3F000000 -> Q=0x7F800000, overflow=1; A=0x00800000, B=0x40000000 -> Q=0x00000000, underflow=1.
5. start held high throughout an operation -> second operand set not latched until after done; rst at DIVIDE cycle 10 -> no done pulse, Q=0, busy=0 next cycle, and a fresh start completes correctly.
6. With FPDIV_EARLY_DONE_EN defined: A=0x3F800000, B=0x00000000 -> done 2 cycles after start; normal operands still take 29 cycles.
